mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 11 +
 rtl/mul_arbiter_mul.sv | 25 ++
 rtl/mul_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared constants for the two-requester multiplier arbiter.
// Holds the FSM state encodings and the settle-counter width.
package mul_arbiter_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_arbiter_mul.sv
// Combinational unsigned SIZE x SIZE array multiplier.
// Ports: a, b (SIZE-bit operands) -> p (2*SIZE-bit exact product).
module mul_arbiter_mul #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] p
);

    logic [2*SIZE-1:0] a_ext;

    assign a_ext = {{SIZE{1'b0}}, a};

    // Sum of shifted partial-product rows, one row per bit of b.
    always_comb begin
        p = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) begin
                p = p + (a_ext << i);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one array multiplier between two requesters.
// Ports: clk, rst, req0/req1 valid/ready/a/b, res_valid/res_ready/res_data/res_id.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SIZE-1:0]   req0_a,
    input  logic [SIZE-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SIZE-1:0]   req1_a,
    input  logic [SIZE-1:0]   req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*SIZE-1:0] res_data,
    output logic              res_id
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic [SIZE-1:0]   op_a;
    logic [SIZE-1:0]   op_b;
    logic              op_id;
    logic [2*SIZE-1:0] product;
    logic              idle;
    logic              grant1;

    assign idle = (state == ST_IDLE) && !rst;

    // On a tie the requester that did not win last time is served.
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && grant1;
    assign res_valid  = (state == ST_DONE);

    mul_arbiter_mul #(
        .SIZE(SIZE)
    ) u_mul (
        .a(op_a),
        .b(op_b),
        .p(product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a       <= req1_ready ? req1_a : req0_a;
                        op_b       <= req1_ready ? req1_b : req0_b;
                        op_id      <= req1_ready;
                        last_grant <= req1_ready;
                        cnt        <= CNT_W'(SETTLE);
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        res_data <= product;
                        res_id   <= op_id;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
